// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for initiators and slaves on this bus.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-beat initiator: valid/ready commands in, one in-order response per command out.
// Address phase (AP) and data phase (DP) registers overlap so a zero-wait slave gets one transfer/cycle.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [ADDR_W-1:0] WordMask = ~ADDR_W'(3);

  logic              ap_valid_q, ap_valid_d;
  logic [ADDR_W-1:0] ap_addr_q, ap_addr_d;
  logic              ap_we_q, ap_we_d;
  logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_we_q, dp_we_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              err_hold_q, err_hold_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic accept, ap_adv, dp_done;

  // err_hold retracts the AP command for one cycle so the second ERROR cycle sees IDLE.
  always_comb begin
    cmd_ready = ~HRESET & (~ap_valid_q | HREADY) & ~err_hold_q;
    accept    = cmd_valid & cmd_ready;
    ap_adv    = ap_valid_q & HREADY & ~err_hold_q;
    dp_done   = dp_valid_q & HREADY;
  end

  always_comb begin
    ap_valid_d  = ap_valid_q;
    ap_addr_d   = ap_addr_q;
    ap_we_d     = ap_we_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_we_d     = dp_we_q;
    hwdata_d    = hwdata_q;
    err_hold_d  = err_hold_q;
    rsp_valid_d = dp_done;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (accept) begin
      ap_valid_d = 1'b1;
      ap_addr_d  = cmd_addr & WordMask;
      ap_we_d    = cmd_we;
      ap_wdata_d = cmd_wdata;
    end else if (ap_adv) begin
      ap_valid_d = 1'b0;
    end

    if (ap_adv) begin
      dp_valid_d = 1'b1;
      dp_we_d    = ap_we_q;
      hwdata_d   = ap_wdata_q;
    end else if (dp_done) begin
      dp_valid_d = 1'b0;
    end

    if (err_hold_q) begin
      if (HREADY) err_hold_d = 1'b0;
    end else if (dp_valid_q & HRESP & ~HREADY) begin
      err_hold_d = 1'b1;
    end

    if (dp_done) begin
      rsp_err_d   = HRESP;
      rsp_rdata_d = dp_we_q ? '0 : HRDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (HRESET) begin
      ap_valid_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_we_q     <= 1'b0;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_we_q     <= 1'b0;
      hwdata_q    <= '0;
      err_hold_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ap_valid_q  <= ap_valid_d;
      ap_addr_q   <= ap_addr_d;
      ap_we_q     <= ap_we_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_we_q     <= dp_we_d;
      hwdata_q    <= hwdata_d;
      err_hold_q  <= err_hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    HADDR     = ap_addr_q;
    HTRANS    = (ap_valid_q & ~err_hold_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    HWRITE    = ap_we_q;
    HSIZE     = HSIZE_WORD;
    HBURST    = HBURST_SINGLE;
    HWDATA    = hwdata_q;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: random command streams checked against an ordered word-memory model,
// with a bench-side AHB slave that inserts wait states and two-cycle ERROR responses.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned Words = 128;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } rsp_t;

  logic          CLK = 1'b0;
  logic          HRESET;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE, HBURST;
  logic [DW-1:0] HWDATA, HRDATA;
  logic          HREADY, HRESP;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;

  ahb_lite_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [Words];
  logic [DW-1:0] sl_mem  [Words];
  cmd_t bus_q[$];
  rsp_t rsp_q[$];
  cmd_t dir_q[$];

  cmd_t cur;
  bit   pend;
  int   cyc, ncmd_left, wait_max, valid_pct;
  bit   use_err, lat_chk;

  bit            sl_act, sl_we, sl_err2;
  logic [AW-1:0] sl_addr;
  logic [DW-1:0] sl_wdata;
  int            sl_waits;

  bit            prev_hready, prev_err1;
  logic [AW-1:0] prev_haddr;
  logic [1:0]    prev_htrans;
  logic          prev_hwrite;
  logic [DW-1:0] prev_hwdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Slave property: words in 0x100..0x13F with bit 2 clear answer ERROR.
  function automatic bit is_err(input logic [AW-1:0] a);
    return (a[8:6] == 3'b100) && !a[2];
  endfunction

  function automatic int unsigned widx(input logic [AW-1:0] a);
    return {25'd0, a[8:2]};
  endfunction

  function automatic cmd_t rand_cmd(input bit err_ok);
    cmd_t c;
    c.addr  = $urandom();
    if (!err_ok && is_err(c.addr)) c.addr[8] = 1'b0;
    c.we    = 1'($urandom_range(1));
    c.wdata = $urandom();
    return c;
  endfunction

  function automatic cmd_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d;
    return c;
  endfunction

  task automatic model_accept(input cmd_t c);
    rsp_t r;
    cmd_t b;
    b      = c;
    b.addr = c.addr & ~32'h3;
    bus_q.push_back(b);
    r.err = is_err(b.addr);
    r.cyc = cyc + 1;
    if (c.we) begin
      r.rdata = '0;
      if (!r.err) ref_mem[widx(b.addr)] = c.wdata;
    end else begin
      r.rdata = r.err ? '0 : ref_mem[widx(b.addr)];
    end
    rsp_q.push_back(r);
  endtask

  task automatic step();
    rsp_t r;
    cmd_t b;
    bit   in_err2, err1, exp_ready;
    @(negedge CLK);
    cyc++;
    in_err2 = sl_err2;

    if (rsp_valid) begin
      if (rsp_q.size() == 0) check_eq("rsp_spurious", rsp_valid, 1'b0);
      else begin
        r = rsp_q.pop_front();
        check_eq("rsp_rdata", rsp_rdata, r.rdata);
        check_eq("rsp_err", rsp_err, r.err);
        if (lat_chk) check_eq("rsp_latency", cyc - r.cyc, 2);
      end
    end

    if (HTRANS == HTRANS_NONSEQ) begin
      check_eq("hsize", HSIZE, HSIZE_WORD);
      check_eq("hburst", HBURST, HBURST_SINGLE);
    end else begin
      check_eq("htrans_legal", HTRANS, HTRANS_IDLE);
    end

    if (!prev_hready) begin
      check_eq("hwdata_hold", HWDATA, prev_hwdata);
      if (!prev_err1 && prev_htrans == HTRANS_NONSEQ) begin
        check_eq("haddr_hold", HADDR, prev_haddr);
        check_eq("htrans_hold", HTRANS, prev_htrans);
        check_eq("hwrite_hold", HWRITE, prev_hwrite);
      end
    end
    if (in_err2) check_eq("htrans_retract", HTRANS, HTRANS_IDLE);

    // Slave: decide this cycle's response for the transfer in its data phase.
    err1   = 1'b0;
    HRESP  = 1'b0;
    HRDATA = $urandom();
    if (in_err2) begin
      HREADY = 1'b1; HRESP = 1'b1; HRDATA = '0;
    end else if (sl_act && is_err(sl_addr)) begin
      HREADY = 1'b0; HRESP = 1'b1; HRDATA = '0; err1 = 1'b1;
    end else if (sl_act && sl_waits > 0) begin
      HREADY = 1'b0;
      sl_waits--;
    end else begin
      HREADY = 1'b1;
      if (sl_act && sl_we) begin
        check_eq("hwdata", HWDATA, sl_wdata);
        sl_mem[widx(sl_addr)] = HWDATA;
      end else if (sl_act) begin
        HRDATA = sl_mem[widx(sl_addr)];
      end
    end
    sl_err2 = err1;
    if (HREADY) begin
      sl_act = 1'b0;
      if (HTRANS == HTRANS_NONSEQ) begin
        if (bus_q.size() == 0) check_eq("bus_spurious", HTRANS, HTRANS_IDLE);
        else begin
          b = bus_q.pop_front();
          check_eq("haddr", HADDR, b.addr);
          check_eq("hwrite", HWRITE, b.we);
          sl_act   = 1'b1;
          sl_addr  = b.addr;
          sl_we    = b.we;
          sl_wdata = b.wdata;
          sl_waits = ($urandom_range(2) == 0) ? $urandom_range(wait_max) : 0;
        end
      end
    end

    if (!pend) begin
      if (dir_q.size() > 0) begin
        cur = dir_q.pop_front(); pend = 1'b1;
      end else if (ncmd_left > 0 && $urandom_range(99) < valid_pct) begin
        cur = rand_cmd(use_err); pend = 1'b1;
      end
    end
    cmd_valid = pend;
    cmd_we    = pend ? cur.we : 1'($urandom_range(1));
    cmd_addr  = pend ? cur.addr : $urandom();
    cmd_wdata = pend ? cur.wdata : $urandom();

    #1;
    exp_ready = !in_err2 && (HTRANS != HTRANS_NONSEQ || HREADY);
    check_eq("cmd_ready", cmd_ready, exp_ready);
    if (cmd_valid && cmd_ready) begin
      model_accept(cur);
      pend = 1'b0;
      ncmd_left--;
    end

    prev_hready = HREADY;
    prev_err1   = err1;
    prev_haddr  = HADDR;
    prev_htrans = HTRANS;
    prev_hwrite = HWRITE;
    prev_hwdata = HWDATA;
  endtask

  task automatic run_phase(input int n, input int wmax, input int vpct, input bit err_ok,
                           input bit lat);
    int guard;
    ncmd_left = n + dir_q.size();
    wait_max  = wmax;
    valid_pct = vpct;
    use_err   = err_ok;
    lat_chk   = lat;
    guard     = 0;
    while ((ncmd_left > 0 || rsp_q.size() > 0 || sl_act) && guard < 5000) begin
      step();
      guard++;
    end
    check_eq("phase_rsp_drain", rsp_q.size(), 0);
    check_eq("phase_bus_drain", bus_q.size(), 0);
  endtask

  initial begin
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    for (int i = 0; i < Words; i++) begin
      ref_mem[i] = '0;
      sl_mem[i]  = '0;
    end
    pend = 1'b0; sl_act = 1'b0; sl_err2 = 1'b0; sl_waits = 0;
    prev_hready = 1'b1; prev_err1 = 1'b0; cyc = 0;
    cur = mk(1'b0, '0, '0);

    repeat (3) @(negedge CLK);
    check_eq("rst_htrans", HTRANS, HTRANS_IDLE);
    check_eq("rst_haddr", HADDR, 0);
    check_eq("rst_hwrite", HWRITE, 0);
    check_eq("rst_hwdata", HWDATA, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    HRESET = 1'b0;

    // Write then read back one word, zero-wait.
    dir_q.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF));
    dir_q.push_back(mk(1'b0, 32'h10, '0));
    run_phase(0, 0, 100, 1'b0, 1'b1);

    // Back-to-back streaming: 4 writes then 4 reads.
    for (int i = 0; i < 4; i++) dir_q.push_back(mk(1'b1, AW'(4 * i), DW'(i + 1)));
    for (int i = 0; i < 4; i++) dir_q.push_back(mk(1'b0, AW'(4 * i), '0));
    run_phase(0, 0, 100, 1'b0, 1'b1);

    // Unaligned address is word-aligned on the bus.
    dir_q.push_back(mk(1'b1, 32'h13, 32'h5A5A_0013));
    dir_q.push_back(mk(1'b0, 32'h10, '0));
    run_phase(0, 0, 100, 1'b0, 1'b1);

    // ERROR on a write with a read queued behind it in the address phase.
    dir_q.push_back(mk(1'b1, 32'h100, 32'h1111_2222));
    dir_q.push_back(mk(1'b0, 32'h104, '0));
    run_phase(0, 0, 100, 1'b1, 1'b0);

    run_phase(120, 0, 100, 1'b0, 1'b1);
    run_phase(400, 3, 70, 1'b1, 1'b0);

    // Reset during the data phase of a read.
    @(negedge CLK);
    HREADY = 1'b1; HRESP = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h10;
    #1 check_eq("rstx_accept", cmd_ready, 1'b1);
    @(negedge CLK);
    cmd_valid = 1'b0;
    check_eq("rstx_ap_htrans", HTRANS, HTRANS_NONSEQ);
    @(negedge CLK);
    HRDATA = 32'hCAFE_F00D;
    HRESET = 1'b1;
    #1 check_eq("rstx_ready_low", cmd_ready, 1'b0);
    @(negedge CLK);
    check_eq("rstx_rsp_valid", rsp_valid, 0);
    check_eq("rstx_htrans", HTRANS, HTRANS_IDLE);
    check_eq("rstx_haddr", HADDR, 0);
    check_eq("rstx_hwrite", HWRITE, 0);
    check_eq("rstx_hwdata", HWDATA, 0);
    check_eq("rstx_rsp_rdata", rsp_rdata, 0);
    check_eq("rstx_rsp_err", rsp_err, 0);
    HRESET = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check_eq("rstx_no_rsp", rsp_valid, 0);
    end
    pend = 1'b0; sl_act = 1'b0; sl_err2 = 1'b0;
    prev_hready = 1'b1; prev_err1 = 1'b0;

    run_phase(150, 2, 80, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
